// File: rtl/score_bcd_pkg.sv
// Shared constants and state encoding for the score-to-BCD converter.
// Imported by the converter top and its testbench-facing defaults.
package score_bcd_pkg;

    localparam int SCORE_W      = 17;
    localparam int SCORE_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Elaboration-time helper: 10**n without relying on 32-bit int overflow.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] fixed
);

    assign fixed = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_bcd.sv
// Sequential binary-to-BCD converter for the score display, with a registered
// digit-select read port feeding the glyph renderer one digit at a time.
module score_bcd
    import score_bcd_pkg::*;
#(
    parameter int BIN_W  = SCORE_W,
    parameter int DIGITS = SCORE_DIGITS,
    parameter int SEL_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    input  logic [SEL_W-1:0]      digit_sel,
    output logic [3:0]            char,
    output logic                  blank
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if ((64'd1 << BIN_W) > pow10(DIGITS)) begin : g_bad_digits
        $error("score_bcd: DIGITS too small to hold the largest BIN_W value");
    end
    if ((1 << SEL_W) < DIGITS) begin : g_bad_sel
        $error("score_bcd: SEL_W cannot address every digit");
    end

    state_t                   state;
    logic [BIN_W-1:0]         shreg;
    logic [SCR_W-1:0]         scratch;
    logic [SCR_W-1:0]         corrected;
    logic [SCR_W+BIN_W-1:0]   shifted;
    logic [CNT_W-1:0]         cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble (scratch[4*g +: 4]),
            .fixed  (corrected[4*g +: 4])
        );
    end

    // Correct every digit first, then shift the binary MSB into scratch bit 0.
    assign shifted = {corrected, shreg} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted[SCR_W+BIN_W-1 -: SCR_W];
                    shreg   <= shifted[BIN_W-1:0];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high here; it drops in the following IDLE cycle.
                    bcd   <= scratch;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [3:0] char_nxt;
    logic       upper_zero;
    logic       blank_nxt;

    always_comb begin
        char_nxt   = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(digit_sel) == i) begin
                char_nxt = bcd[4*i +: 4];
            end
            if (i >= int'(digit_sel) && bcd[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        blank_nxt = (int'(digit_sel) >= DIGITS) || ((digit_sel != '0) && upper_zero);
    end

    // Read port looks only at the committed bcd, so partial results never reach the screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char  <= '0;
            blank <= 1'b0;
        end else begin
            char  <= char_nxt;
            blank <= blank_nxt;
        end
    end

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: vector table, randomized conversions
// against a decimal reference model, and hand-written handshake/reset sequences.
module tb_score_bcd;

    localparam int BIN_W  = 17;
    localparam int DIGITS = 6;
    localparam int SEL_W  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [SEL_W-1:0]    digit_sel;
    logic [3:0]          char;
    logic                blank;

    int checks = 0;
    int errors = 0;

    score_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .digit_sel (digit_sel),
        .char      (char),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned bin;
        int          sel;
        logic [23:0] exp_bcd;
        logic [3:0]  exp_char;
        logic        exp_blank;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain decimal arithmetic on the integer value.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_char(input int unsigned v, input int sel);
        if (sel >= DIGITS) return 4'd0;
        return 4'((v / int'(10 ** sel)) % 10);
    endfunction

    function automatic logic ref_blank(input int unsigned v, input int sel);
        if (sel >= DIGITS) return 1'b1;
        if (sel == 0) return 1'b0;
        return v < int'(10 ** sel);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input int unsigned v);
        int lat;
        start = 1'b1;
        bin   = BIN_W'(v);
        tick();
        chk("busy_after_accept", 32'(busy), 32'd1);
        start = 1'b0;
        bin   = BIN_W'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, 18);
        chk("bcd", 32'(bcd), 32'(ref_bcd(v)));
        tick();
        chk("done_single_cycle", 32'(done), 32'd0);
    endtask

    task automatic read_chk(input int sel, input logic [3:0] ec, input logic eb);
        digit_sel = SEL_W'(sel);
        tick();
        chk("char", 32'(char), 32'(ec));
        chk("blank", 32'(blank), 32'(eb));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned prev;
        int np;
        int first;
        int last;
        bit ival_ok;
        bit stable_ok;
        int n;

        vecs.push_back(vec_t'{0,      0, 24'h000000, 4'd0, 1'b0});
        vecs.push_back(vec_t'{0,      1, 24'h000000, 4'd0, 1'b1});
        vecs.push_back(vec_t'{2048,   0, 24'h002048, 4'd8, 1'b0});
        vecs.push_back(vec_t'{2048,   1, 24'h002048, 4'd4, 1'b0});
        vecs.push_back(vec_t'{2048,   2, 24'h002048, 4'd0, 1'b0});
        vecs.push_back(vec_t'{2048,   3, 24'h002048, 4'd2, 1'b0});
        vecs.push_back(vec_t'{2048,   4, 24'h002048, 4'd0, 1'b1});
        vecs.push_back(vec_t'{2048,   5, 24'h002048, 4'd0, 1'b1});
        vecs.push_back(vec_t'{2048,   7, 24'h002048, 4'd0, 1'b1});
        vecs.push_back(vec_t'{131071, 0, 24'h131071, 4'd1, 1'b0});
        vecs.push_back(vec_t'{131071, 1, 24'h131071, 4'd7, 1'b0});
        vecs.push_back(vec_t'{131071, 2, 24'h131071, 4'd0, 1'b0});
        vecs.push_back(vec_t'{131071, 3, 24'h131071, 4'd1, 1'b0});
        vecs.push_back(vec_t'{131071, 4, 24'h131071, 4'd3, 1'b0});
        vecs.push_back(vec_t'{131071, 5, 24'h131071, 4'd1, 1'b0});
        vecs.push_back(vec_t'{99999,  4, 24'h099999, 4'd9, 1'b0});
        vecs.push_back(vec_t'{99999,  5, 24'h099999, 4'd0, 1'b1});

        rst       = 1'b1;
        start     = 1'b0;
        bin       = '0;
        digit_sel = '0;
        tick();
        tick();
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_bcd",   32'(bcd),   32'd0);
        chk("rst_char",  32'(char),  32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven vectors
        prev = 32'hFFFF_FFFF;
        foreach (vecs[i]) begin
            if (vecs[i].bin != prev) begin
                convert(vecs[i].bin);
                chk("table_bcd", 32'(bcd), 32'(vecs[i].exp_bcd));
                prev = vecs[i].bin;
            end
            read_chk(vecs[i].sel, vecs[i].exp_char, vecs[i].exp_blank);
        end

        // Randomized conversions against the reference model
        for (int k = 0; k < 30; k++) begin
            int unsigned v;
            int s;
            v = $urandom_range(0, 131071);
            convert(v);
            for (int r = 0; r < 2; r++) begin
                s = $urandom_range(0, 7);
                read_chk(s, ref_char(v, s), ref_blank(v, s));
            end
        end

        // Start during SHIFT is ignored
        start = 1'b1;
        bin   = BIN_W'(2048);
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        bin   = BIN_W'(4096);
        tick();
        start = 1'b0;
        np = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin
                np++;
                chk("ignored_start_bcd", 32'(bcd), 32'h002048);
            end
        end
        chk("ignored_start_pulses", np, 1);

        // Reset mid-conversion
        start = 1'b1;
        bin   = BIN_W'(512);
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bcd",  32'(bcd),  32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        np = 0;
        repeat (25) begin
            tick();
            if (done) np++;
        end
        chk("midrst_no_done", np, 0);
        convert(512);

        // Back-to-back with start held high
        digit_sel = SEL_W'(2);
        start     = 1'b1;
        bin       = BIN_W'(64);
        first     = -1;
        last      = -1;
        np        = 0;
        ival_ok   = 1'b1;
        stable_ok = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done) begin
                if (last >= 0 && (c - last) != 19) ival_ok = 1'b0;
                if (first < 0) first = c;
                last = c;
                np++;
            end
            if (first >= 0 && c > first) begin
                if (bcd !== 24'h000064) stable_ok = 1'b0;
                if (blank !== 1'b1 || char !== 4'd0) stable_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", first, 18);
        chk("b2b_pulses", np, 4);
        chk("b2b_interval", 32'(ival_ok), 32'd1);
        chk("b2b_stable", 32'(stable_ok), 32'd1);
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("b2b_drain", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
